// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// the quotient pattern reported for a zero divisor.
package seq_restoring_divider_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Sliced down to the operand width by the user; supports widths up to 64.
  localparam logic [63:0] DIV0_QUOT_FILL = '1;

endpackage

// File: rtl/seq_restoring_divider_addsub.sv
// N-bit ripple-carry adder/subtractor: b is inverted by sub, and sub is the
// carry-in, so sub=1 yields a - b in two's complement.
module nbit_addsub #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);

  logic [W-1:0] b_x;
  logic [W-1:0] carry;

  assign b_x      = b ^ {W{sub}};
  assign carry[0] = sub;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i] = a[i] ^ b_x[i] ^ carry[i];
    // The carry out of the top bit is not needed by any user.
    if (i < W - 1) begin : g_carry
      assign carry[i+1] = (a[i] & b_x[i]) | (a[i] & carry[i]) | (b_x[i] & carry[i]);
    end
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock through a
// shared WIDTH+1-bit subtractor; results held until the next accepted request.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // state | meaning
  // IDLE  | waiting for start
  // CALC  | one trial subtraction per cycle, cnt counts down the remaining bits
  // DONE  | results valid for this single cycle; start may be re-accepted here
  localparam int              CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  // The partial remainder always stays below the divisor, so it fits in WIDTH
  // bits; the extra bit only exists on the shifted value feeding the subtractor.
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quo_shift;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign quo_shift = {quo_q[WIDTH-2:0], 1'b0};

  nbit_addsub #(
    .W (WIDTH + 1)
  ) u_addsub (
    .a   (rem_shift),
    .b   ({1'b0, dsr_q}),
    .sub (1'b1),
    .sum (trial)
  );

  always_comb begin
    if (trial[WIDTH]) begin
      rem_next = rem_shift[WIDTH-1:0];
      quo_next = quo_shift;
    end else begin
      rem_next = trial[WIDTH-1:0];
      quo_next = quo_shift | {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dsr_d       = dsr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (divisor != '0) begin
            quo_d   = dividend;
            rem_d   = '0;
            dsr_d   = divisor;
            cnt_d   = CNT_LAST;
            dbz_d   = 1'b0;
            state_d = ST_CALC;
          end else begin
            quotient_d  = DIV0_QUOT_FILL[WIDTH-1:0];
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CALC: begin
        rem_d = rem_next;
        quo_d = quo_next;
        // Results are captured on the way into DONE so they are visible with done.
        if (cnt_q == '0) begin
          quotient_d  = quo_next;
          remainder_d = rem_next;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dsr_q       <= dsr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == ST_CALC);
  assign done        = (state_q == ST_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
